booth_r4_seq_mult: RTL and testbench

//  - Iterative signed radix-4 Booth multiplier: N x N two's-complement -> 2N product, one Booth digit per clock.
//  - Uses the same single/double/negative digit recoding as the combinational Booth array.
//  - Area-lean sequential alternative that feeds the N-bit adder datapath.
//  - Valid/ready on both input and output; sits between the operand source and result consumer.

---
 rtl/booth_pkg.sv | 39 +++
 rtl/booth_r4_pp_gen.sv | 28 ++
 rtl/booth_r4_seq_mult.sv | 154 +++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and Booth radix-4 recode table for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // One recoded Booth digit: magnitude select (x1 / x2) and sign.
    typedef struct packed {
        logic single;
        logic dbl;
        logic neg;
    } booth_digit_t;

    localparam booth_digit_t DIG_ZERO = '{single: 1'b0, dbl: 1'b0, neg: 1'b0};
    localparam booth_digit_t DIG_POS1 = '{single: 1'b1, dbl: 1'b0, neg: 1'b0};
    localparam booth_digit_t DIG_POS2 = '{single: 1'b0, dbl: 1'b1, neg: 1'b0};
    localparam booth_digit_t DIG_NEG2 = '{single: 1'b0, dbl: 1'b1, neg: 1'b1};
    localparam booth_digit_t DIG_NEG1 = '{single: 1'b1, dbl: 1'b0, neg: 1'b1};

    // Indexed by the window {L[1], L[0], q}; entry 7 first.
    localparam logic [7:0][2:0] RECODE_TBL = {
        DIG_ZERO,   // 111
        DIG_NEG1,   // 110
        DIG_NEG1,   // 101
        DIG_NEG2,   // 100
        DIG_POS2,   // 011
        DIG_POS1,   // 010
        DIG_POS1,   // 001
        DIG_ZERO    // 000
    };

    function automatic booth_digit_t booth_recode(input logic [2:0] win);
        return booth_digit_t'(RECODE_TBL[win]);
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Booth radix-4 partial-product generator: selects 0/M/2M and inverts for
// negative digits; the +1 of the two's complement is the adder carry-in.
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2:0]   win_i,
    input  logic [N+1:0] m_i,
    output booth_digit_t digit_o,
    output logic [N+1:0] pp_o
);

    logic [N+1:0] sel;

    // Recode the window, pick the magnitude, apply the sign by inversion.
    always_comb begin
        digit_o = booth_recode(win_i);
        sel     = '0;
        if (digit_o.single) begin
            sel = m_i;
        end else if (digit_o.dbl) begin
            sel = {m_i[N:0], 1'b0};
        end
        pp_o = digit_o.neg ? ~sel : sel;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, one Booth digit per clock,
// valid/ready on both sides. Result appears N/2+1 cycles after acceptance.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P,
    output logic           O
);

    localparam int unsigned W     = N + 2;
    localparam int unsigned HALF  = N / 2;
    localparam int unsigned CNT_W = $clog2(HALF + 1);

    booth_state_t state_q, state_d;

    logic [W-1:0]     m_q, m_d;
    logic [W-1:0]     h_q, h_d;
    logic [N-1:0]     l_q, l_d;
    logic             q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   p_q, p_d;
    logic             o_q, o_d;

    logic             accept;
    logic             consume;
    logic             last_iter;
    booth_digit_t     digit;
    logic [W-1:0]     pp;
    logic             cin;
    logic [W-1:0]     t_sum;
    logic [2*N-1:0]   prod;
    logic [N:0]       prod_top;

    assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
    assign consume   = (state_q == DONE) && out_valid_q && out_ready;
    assign last_iter = (cnt_q == CNT_W'(HALF - 1));

    booth_r4_pp_gen #(
        .N(N)
    ) u_pp_gen (
        .win_i  ({l_q[1:0], q_q}),
        .m_i    (m_q),
        .digit_o(digit),
        .pp_o   (pp)
    );

    // A zero digit never needs the two's-complement carry.
    assign cin      = digit.neg & (digit.single | digit.dbl);
    assign t_sum    = h_q + pp + W'(cin);
    assign prod     = {h_q[N-1:0], l_q};
    assign prod_top = prod[2*N-1:N-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = RUN;
            RUN:  if (last_iter) state_d = DONE;
            DONE: if (consume)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered handshake and result.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = 1'b0;
        p_d         = p_q;
        o_d         = o_q;
        if (state_q == DONE) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                p_d         = prod;
                o_d         = ~((&prod_top) | ~(|prod_top));
            end else begin
                out_valid_d = ~out_ready;
            end
        end
    end

    // Datapath: operand capture, then one add-and-shift-by-2 per RUN cycle.
    always_comb begin
        m_d   = m_q;
        h_d   = h_q;
        l_d   = l_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (accept) begin
            m_d   = {{2{A[N-1]}}, A};
            h_d   = '0;
            l_d   = B;
            q_d   = 1'b0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            h_d   = {{2{t_sum[W-1]}}, t_sum[W-1:2]};
            l_d   = {t_sum[1:0], l_q[N-1:2]};
            q_d   = l_q[1];
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q         <= '0;
            h_q         <= '0;
            l_q         <= '0;
            q_q         <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            o_q         <= 1'b0;
        end else begin
            m_q         <= m_d;
            h_q         <= h_d;
            l_q         <= l_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            o_q         <= o_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign O         = o_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult (N=32): directed, backpressure, reset and
// randomized back-to-back checks against a plain-arithmetic reference.
module tb_booth_r4_seq_mult;

    localparam int unsigned N   = 32;
    localparam int          LAT = 17;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  a         = '0;
    logic [N-1:0]  b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic [2*N-1:0] p;
    logic          o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(
        .N(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (a),
        .B        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .P        (p),
        .O        (o)
    );

    // Reference: exact signed product and "does not fit in N signed bits".
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y);
        longint pr = longint'($signed(x)) * longint'($signed(y));
        return (pr > 64'sd2147483647) || (pr < -64'sd2147483648);
    endfunction

    // Issue one operation and wait for out_valid; caller owns out_ready.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] pv, output logic ov, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        pv = p;
        ov = o;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (p !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_P: got %h expected 0", p);
        end
        vectors++;
        if (o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_O: got %b expected 0", o);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] xa [5];
        logic [31:0] ya [5];
        logic [63:0] pe [5];
        logic        oe [5];
        logic [63:0] pv;
        logic        ov;
        int          lat;
        xa = '{32'd3, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00010000};
        ya = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
        pe = '{64'h000000000000000F, 64'h0000000000000001, 64'hFFFFFFFF80000001,
               64'h4000000000000000, 64'h0000000100000000};
        oe = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            do_op(xa[i], ya[i], pv, ov, lat);
            vectors++;
            if (pv !== pe[i]) begin
                miscompares++;
                $display("FAIL directed_P[%0d]: got %h expected %h", i, pv, pe[i]);
            end
            vectors++;
            if (ov !== oe[i]) begin
                miscompares++;
                $display("FAIL directed_O[%0d]: got %b expected %b", i, ov, oe[i]);
            end
            vectors++;
            if (lat !== LAT) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] pe;
        logic        oe;
        int          lat;
        x  = $urandom;
        y  = $urandom;
        pe = ref_prod(x, y);
        oe = ref_ovf(x, y);
        out_ready = 1'b0;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Keep offering different operands while the multiply is busy.
        lat = 0;
        while (!out_valid && lat < 100) begin
            a = $urandom;
            b = $urandom;
            in_valid = $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
        end
        for (int c = 0; c < 5; c++) begin
            a = $urandom;
            b = $urandom;
            in_valid = (c % 2) == 0;
            vectors++;
            if (p !== pe || o !== oe || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got P=%h O=%b ov=%b ir=%b expected P=%h O=%b ov=1 ir=0",
                         c, p, o, out_valid, in_ready, pe, oe);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready);
        end
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_capture: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] pv;
        logic        ov;
        int          lat;
        out_ready = 1'b0;
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || p !== 64'h0) begin
            miscompares++;
            $display("FAIL rst_run: got ov=%b P=%h expected ov=0 P=0", out_valid, p);
        end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_run_in_ready: got %b expected 1", in_ready);
        end
        // Reset while a result is being presented.
        do_op(32'h12345678, 32'h9ABCDEF0, pv, ov, lat);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || p !== 64'h0 || o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_done: got ov=%b P=%h O=%b expected ov=0 P=0 O=0", out_valid, p, o);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_done_in_ready: got %b expected 1", in_ready);
        end
        do_op(32'd7, 32'hFFFFFFFA, pv, ov, lat);
        vectors++;
        if (pv !== 64'hFFFFFFFFFFFFFFD6 || ov !== 1'b0 || lat !== LAT) begin
            miscompares++;
            $display("FAIL rst_next_op: got P=%h O=%b lat=%0d expected P=ffffffffffffffd6 O=0 lat=%0d",
                     pv, ov, lat, LAT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] cv [5];
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] pv;
        logic        ov;
        int          lat;
        cv = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 25 + 2000; i++) begin
            if (i < 25) begin
                x = cv[i / 5];
                y = cv[i % 5];
            end else begin
                x = ($urandom_range(0, 7) == 0) ? cv[$urandom_range(0, 4)] : 32'($urandom);
                y = ($urandom_range(0, 7) == 0) ? cv[$urandom_range(0, 4)] : 32'($urandom);
            end
            do_op(x, y, pv, ov, lat);
            vectors++;
            if (pv !== ref_prod(x, y)) begin
                miscompares++;
                $display("FAIL rand_P A=%h B=%h: got %h expected %h", x, y, pv, ref_prod(x, y));
            end
            vectors++;
            if (ov !== ref_ovf(x, y)) begin
                miscompares++;
                $display("FAIL rand_O A=%h B=%h: got %b expected %b", x, y, ov, ref_ovf(x, y));
            end
            vectors++;
            if (lat !== LAT) begin
                miscompares++;
                $display("FAIL rand_latency A=%h B=%h: got %0d expected %0d", x, y, lat, LAT);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
